// File: rtl/seq_cla_pkg.sv
// Shared types and elaboration helpers for the multi-cycle carry-lookahead adder.
package seq_cla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic bit params_ok(input int width, input int chunk);
    return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0) && ((chunk % 4) == 0);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_cla_adder_slice.sv
// Combinational CHUNK-bit adder: 4-bit group lookahead plus a second lookahead level across groups.
module cla_slice #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o,
  output logic             c_msb_o,
  output logic             p_slice_o,
  output logic             g_slice_o
);

  localparam int NG = CHUNK / 4;

  logic [CHUNK-1:0] p;
  logic [CHUNK-1:0] g;
  logic [CHUNK-1:0] c;
  logic [NG-1:0]    gp;
  logic [NG-1:0]    gg;
  logic [NG:0]      gc;
  logic             t;
  logic             gacc;

  always_comb begin
    p    = a_i ^ b_i;
    g    = a_i & b_i;
    gp   = '0;
    gg   = '0;
    gc   = '0;
    c    = '0;
    t    = 1'b0;
    gacc = 1'b0;

    for (int k = 0; k < NG; k++) begin
      gp[k] = &p[4*k +: 4];
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end

    // Flat sum-of-products carry into every group, no ripple through gc.
    for (int k = 0; k <= NG; k++) begin
      t = cin_i;
      for (int m = 0; m < k; m++) t = t & gp[m];
      gc[k] = t;
      for (int j = 0; j < k; j++) begin
        t = gg[j];
        for (int m = j + 1; m < k; m++) t = t & gp[m];
        gc[k] = gc[k] | t;
      end
    end

    for (int k = 0; k < NG; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end

    for (int j = 0; j < NG; j++) gacc = gg[j] | (gp[j] & gacc);
  end

  assign sum_o     = p ^ c;
  assign cout_o    = gc[NG];
  assign c_msb_o   = c[CHUNK-1];
  assign p_slice_o = &gp;
  assign g_slice_o = gacc;

endmodule

// File: rtl/seq_cla_adder.sv
// Multi-cycle WIDTH-bit add/subtract, one CHUNK slice per cycle, carry rippled through a register.
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | adding slice idx_q each edge
//   DONE  | results loaded, done pulse; start accepted here too
module seq_cla_adder
  import seq_cla_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int CHUNK  = 16,
  parameter int NCHUNK = calc_nchunk(WIDTH, CHUNK)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             P_block,
  output logic             G_block
);

  localparam int IDXW = idx_width(NCHUNK);

  if (!params_ok(WIDTH, CHUNK)) begin : g_bad_params
    $error("seq_cla_adder: WIDTH must be a multiple of CHUNK and CHUNK a multiple of 4");
  end

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  work_q, work_d;
  logic              p_acc_q, p_acc_d;
  logic              g_acc_q, g_acc_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              pblk_q, pblk_d;
  logic              gblk_q, gblk_d;

  logic [CHUNK-1:0]  sl_a, sl_b, sl_sum;
  logic              sl_cout, sl_cmsb, sl_p, sl_g;
  logic              last;

  assign sl_a = a_q[int'(idx_q)*CHUNK +: CHUNK];
  assign sl_b = b_q[int'(idx_q)*CHUNK +: CHUNK];
  assign last = (idx_q == IDXW'(NCHUNK - 1));

  cla_slice #(.CHUNK(CHUNK)) u_slice (
    .a_i       (sl_a),
    .b_i       (sl_b),
    .cin_i     (carry_q),
    .sum_o     (sl_sum),
    .cout_o    (sl_cout),
    .c_msb_o   (sl_cmsb),
    .p_slice_o (sl_p),
    .g_slice_o (sl_g)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    p_acc_d = p_acc_q;
    g_acc_d = g_acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    pblk_d  = pblk_q;
    gblk_d  = gblk_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = RUN;
          a_d     = in_a;
          b_d     = sub ? ~in_b : in_b;
          carry_d = sub | cin;
          p_acc_d = 1'b1;
          g_acc_d = 1'b0;
          idx_d   = '0;
        end
      end
      RUN: begin
        work_d[int'(idx_q)*CHUNK +: CHUNK] = sl_sum;
        carry_d = sl_cout;
        p_acc_d = p_acc_q & sl_p;
        g_acc_d = sl_g | (sl_p & g_acc_q);
        if (last) begin
          // All visible results change together on the edge into DONE.
          state_d = DONE;
          idx_d   = '0;
          sum_d   = work_d;
          cout_d  = sl_cout;
          ovf_d   = sl_cmsb ^ sl_cout;
          pblk_d  = p_acc_d;
          gblk_d  = g_acc_d;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      p_acc_q <= 1'b0;
      g_acc_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      pblk_q  <= 1'b0;
      gblk_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      p_acc_q <= p_acc_d;
      g_acc_q <= g_acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      pblk_q  <= pblk_d;
      gblk_q  <= gblk_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
  assign P_block  = pblk_q;
  assign G_block  = gblk_q;

endmodule

// File: tb/tb_seq_cla_adder.sv
// Self-checking bench for seq_cla_adder (WIDTH=64, CHUNK=16): vector table, random ops, multi-cycle corners.
module tb_seq_cla_adder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        cin;
  logic        sub;
  logic        busy;
  logic        done;
  logic [63:0] sum;
  logic        cout;
  logic        overflow;
  logic        P_block;
  logic        G_block;

  seq_cla_adder #(.WIDTH(64), .CHUNK(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_a     (in_a),
    .in_b     (in_b),
    .cin      (cin),
    .sub      (sub),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow),
    .P_block  (P_block),
    .G_block  (G_block)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        p;
    logic        g;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[8];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mkv(input logic [63:0] a, input logic [63:0] b, input logic ci,
                               input logic sb_, input logic [63:0] s, input logic co,
                               input logic ov, input logic p, input logic g);
    vec_t v;
    v.a = a; v.b = b; v.cin = ci; v.sub = sb_;
    v.sum = s; v.cout = co; v.ovf = ov; v.p = p; v.g = g;
    return v;
  endfunction

  // Reference: plain wide arithmetic, independent of any lookahead structure.
  function automatic vec_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic ci, input logic sb_);
    vec_t        v;
    logic [63:0] bp;
    logic        c0;
    logic [64:0] full;
    logic [64:0] nocin;
    logic [63:0] low;
    bp    = sb_ ? ~b : b;
    c0    = sb_ | ci;
    full  = {1'b0, a} + {1'b0, bp} + 65'(c0);
    nocin = {1'b0, a} + {1'b0, bp};
    low   = {1'b0, a[62:0]} + {1'b0, bp[62:0]} + 64'(c0);
    v = mkv(a, b, ci, sb_, full[63:0], full[64], low[63] ^ full[64], &(a ^ bp), nocin[64]);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_start(input vec_t v, input bit push);
    in_a  = v.a;
    in_b  = v.b;
    cin   = v.cin;
    sub   = v.sub;
    start = 1'b1;
    if (push) sb.push_back(v);
  endtask

  // Called one negedge after the accepting edge; returns at the negedge where done is seen.
  task automatic wait_done(input string name, output int cycles, output int busy_cnt);
    cycles   = 1;
    busy_cnt = 0;
    while (!done && cycles < 20) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      cycles++;
    end
    chk({name, "_done_seen"}, 64'(done), 64'd1);
  endtask

  task automatic compare_pop(input string name);
    vec_t v;
    if (sb.size() == 0) begin
      chk({name, "_sb_nonempty"}, 64'd0, 64'd1);
    end else begin
      v = sb.pop_front();
      chk({name, "_sum"},  sum,      v.sum);
      chk({name, "_cout"}, cout,     v.cout);
      chk({name, "_ovf"},  overflow, v.ovf);
      chk({name, "_P"},    P_block,  v.p);
      chk({name, "_G"},    G_block,  v.g);
    end
  endtask

  task automatic run_one(input string name, input vec_t v);
    int cyc, bc;
    @(negedge clk);
    drive_start(v, 1'b1);
    @(negedge clk);
    start = 1'b0;
    in_a  = ~v.a;
    in_b  = ~v.b;
    wait_done(name, cyc, bc);
    chk({name, "_latency"}, 64'(cyc), 64'd5);
    chk({name, "_busy_cycles"}, 64'(bc), 64'd4);
    compare_pop(name);
    @(negedge clk);
    chk({name, "_done_pulse"}, 64'(done), 64'd0);
    chk({name, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v1, v2, junk, vr;
    int   cyc, bc, stray;

    tbl[0] = mkv(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    tbl[1] = mkv(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[2] = mkv(64'h5, 64'h7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[3] = mkv(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[4] = mkv(64'h0, 64'h0, 1'b1, 1'b0, 64'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[5] = mkv(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[6] = mkv(64'h1234, 64'h1234, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[7] = mkv(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 1'b1);

    rst_n = 1'b0;
    start = 1'b0;
    in_a  = 64'h0;
    in_b  = 64'h0;
    cin   = 1'b0;
    sub   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sum",  sum, 64'd0);
    chk("rst_flags", {59'd0, cout, overflow, P_block, G_block, 1'b0}, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_one($sformatf("tbl%0d", i), tbl[i]);

    for (int i = 0; i < 6; i++) begin
      vr = model({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
      run_one($sformatf("rnd%0d", i), vr);
    end

    // Back-to-back: start during RUN ignored, start in DONE accepted with no IDLE gap.
    v1   = model(64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
    v2   = model(64'h0000_0000_0000_0010, 64'h0000_0000_0000_0003, 1'b0, 1'b1);
    junk = model(64'hDEAD_BEEF_0000_0000, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1, 1'b0);
    @(negedge clk);
    drive_start(v1, 1'b1);
    @(negedge clk);
    drive_start(junk, 1'b0);
    @(negedge clk);
    start = 1'b0;
    wait_done("b2b_op1", cyc, bc);
    chk("b2b_op1_latency", 64'(cyc + 1), 64'd5);
    compare_pop("b2b_op1");
    drive_start(v2, 1'b1);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_no_gap_busy", 64'(busy), 64'd1);
    chk("b2b_no_gap_done", 64'(done), 64'd0);
    chk("b2b_held_sum", sum, v1.sum);
    wait_done("b2b_op2", cyc, bc);
    chk("b2b_op2_latency", 64'(cyc), 64'd5);
    chk("b2b_op2_busy_cycles", 64'(bc), 64'd4);
    compare_pop("b2b_op2");
    @(negedge clk);
    chk("b2b_final_idle", 64'(busy | done), 64'd0);

    // Reset at the second RUN edge aborts the operation.
    @(negedge clk);
    drive_start(model(64'h1, 64'h2, 1'b0, 1'b0), 1'b0);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_sum",  sum, 64'd0);
    chk("abort_flags", {60'd0, cout, overflow, P_block, G_block}, 64'd0);
    rst_n = 1'b1;
    stray = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) stray++;
    end
    chk("abort_no_done", 64'(stray), 64'd0);
    run_one("after_abort", model(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0));

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
